// File: rtl/counter_load_ctrl.sv
// Load-and-run sequencer for a 4-bit loadable counter: strobes a preset load,
// then enables counting for run_len cycles (pausable) and ends with a done pulse.
module counter_load_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [3:0] preset,
   input  logic [3:0] run_len,
   input  logic       pause,
   input  logic [3:0] q_in,
   output logic       load,
   output logic       en,
   output logic [3:0] d,
   output logic       busy,
   output logic       done,
   output logic       wrap
);

   // state | meaning
   // IDLE  | waiting for start; captures preset/run_len on acceptance
   // LOAD  | one-cycle load strobe to the counter
   // RUN   | counting; en follows !pause, remaining counts down
   // DONE  | one-cycle end-of-sequence pulse
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t     state, state_nxt;
   logic [3:0] remaining, remaining_nxt;
   logic [3:0] d_reg, d_nxt;
   logic       wrap_reg, wrap_nxt;
   logic       en_int;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         remaining <= 4'd0;
         d_reg     <= 4'd0;
         wrap_reg  <= 1'b0;
      end else begin
         state     <= state_nxt;
         remaining <= remaining_nxt;
         d_reg     <= d_nxt;
         wrap_reg  <= wrap_nxt;
      end
   end

   assign en_int = (state == RUN) && !pause;

   always_comb begin
      state_nxt     = state;
      remaining_nxt = remaining;
      d_nxt         = d_reg;
      wrap_nxt      = wrap_reg;
      unique case (state)
         IDLE: begin
            if (start) begin
               d_nxt         = preset;
               remaining_nxt = run_len;
               wrap_nxt      = 1'b0;
               state_nxt     = LOAD;
            end
         end
         LOAD: begin
            state_nxt = (remaining == 4'd0) ? DONE : RUN;
         end
         RUN: begin
            // remaining is never 0 here: LOAD bypasses RUN for run_len=0
            if (en_int) begin
               remaining_nxt = remaining - 4'd1;
               if (remaining == 4'd1) state_nxt = DONE;
               if (q_in == 4'hf)      wrap_nxt  = 1'b1;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign load = (state == LOAD);
   assign en   = en_int;
   assign busy = (state != IDLE);
   assign done = (state == DONE);
   assign d    = d_reg;
   assign wrap = wrap_reg;

endmodule

// File: tb/tb_counter_load_ctrl.sv
// Directed bench: counter_load_ctrl paired with a 4-bit loadable counter.
module tb_counter_load_ctrl;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] preset;
   logic [3:0] run_len;
   logic       pause;
   logic [3:0] q;
   logic       load;
   logic       en;
   logic [3:0] d;
   logic       busy;
   logic       done;
   logic       wrap;

   int nchk;
   int nerr;

   int         n_load, n_en, n_busy, n_done, q_cnt;
   logic [3:0] q_log [0:15];
   logic       wrap_load;
   logic       ended;

   counter_load_ctrl dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .preset  (preset),
      .run_len (run_len),
      .pause   (pause),
      .q_in    (q),
      .load    (load),
      .en      (en),
      .d       (d),
      .busy    (busy),
      .done    (done),
      .wrap    (wrap)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // downstream counter
   always @(posedge clk or negedge rst) begin
      if (!rst)      q <= 4'd0;
      else if (load) q <= d;
      else if (en)   q <= q + 4'd1;
   end

   // Starts a sequence, then records per-cycle activity until busy drops.
   // cyc 0 is the LOAD cycle. start_at injects a stray start pulse with
   // different preset/run_len in that cycle.
   task automatic do_seq(input logic [3:0] p, input logic [3:0] r,
                         input int pause_from, input int pause_n, input int start_at);
      n_load = 0; n_en = 0; n_busy = 0; n_done = 0; q_cnt = 0;
      wrap_load = 1'bx; ended = 1'b0;
      preset = p; run_len = r; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         pause = (cyc >= pause_from) && (cyc < pause_from + pause_n);
         if (cyc == start_at) begin
            start = 1'b1; preset = p + 4'd3; run_len = r + 4'd5;
         end else begin
            start = 1'b0;
         end
         #1;
         if (!busy) begin
            ended = 1'b1;
            break;
         end
         if (cyc == 0) wrap_load = wrap;
         if (load) n_load++;
         if (en) begin
            n_en++;
            if (q_cnt < 16) q_log[q_cnt] = q;
            q_cnt++;
         end
         if (done) begin
            n_done++;
            if (q_cnt < 16) q_log[q_cnt] = q;
            q_cnt++;
         end
         n_busy++;
         @(posedge clk); #1;
      end
      start = 1'b0; pause = 1'b0;
      nchk++;
      if (ended !== 1'b1) begin
         nerr++;
         $display("FAIL seq_timeout: busy still %b after 40 cycles, required 0", busy);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0; start = 1'b0; preset = 4'd0; run_len = 4'd0; pause = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      nchk++;
      if ({load, en, busy, done, wrap, d} !== 9'd0) begin
         nerr++;
         $display("FAIL reset_outputs: load/en/busy/done/wrap/d=%b, required all 0",
                  {load, en, busy, done, wrap, d});
      end
      rst = 1'b1;
      #1;
      nchk++;
      if ({load, en, busy, done, wrap, d} !== 9'd0) begin
         nerr++;
         $display("FAIL after_release: outputs=%b, required all 0", {load, en, busy, done, wrap, d});
      end
   endtask

   task automatic test_basic;
      logic [3:0] exp_q [0:3];
      exp_q[0] = 4'd5; exp_q[1] = 4'd6; exp_q[2] = 4'd7; exp_q[3] = 4'd8;
      do_seq(4'd5, 4'd3, 99, 0, 99);
      nchk++;
      if (n_load !== 1 || n_en !== 3 || n_done !== 1 || n_busy !== 5) begin
         nerr++;
         $display("FAIL basic_counts: load=%0d en=%0d done=%0d busy=%0d, required 1 3 1 5",
                  n_load, n_en, n_done, n_busy);
      end
      nchk++;
      if (q_cnt !== 4) begin
         nerr++;
         $display("FAIL basic_qlen: %0d samples, required 4", q_cnt);
      end
      for (int i = 0; i < 4; i++) begin
         nchk++;
         if (q_log[i] !== exp_q[i]) begin
            nerr++;
            $display("FAIL basic_q%0d: q=%0d, required %0d", i, q_log[i], exp_q[i]);
         end
      end
      nchk++;
      if (wrap !== 1'b0 || d !== 4'd5) begin
         nerr++;
         $display("FAIL basic_end: wrap=%b d=%0d, required wrap=0 d=5", wrap, d);
      end
   endtask

   task automatic test_zero_len;
      do_seq(4'd9, 4'd0, 99, 0, 99);
      nchk++;
      if (n_load !== 1 || n_en !== 0 || n_done !== 1 || n_busy !== 2) begin
         nerr++;
         $display("FAIL zero_counts: load=%0d en=%0d done=%0d busy=%0d, required 1 0 1 2",
                  n_load, n_en, n_done, n_busy);
      end
      nchk++;
      if (q !== 4'd9) begin
         nerr++;
         $display("FAIL zero_q: q=%0d, required 9", q);
      end
   endtask

   task automatic test_pause;
      logic [3:0] exp_q [0:4];
      exp_q[0] = 4'd5; exp_q[1] = 4'd6; exp_q[2] = 4'd7; exp_q[3] = 4'd8; exp_q[4] = 4'd9;
      // pause in cycles 2,3; also hold pause in LOAD cycle of a later check
      do_seq(4'd5, 4'd4, 2, 2, 99);
      nchk++;
      if (n_load !== 1 || n_en !== 4 || n_done !== 1 || n_busy !== 8) begin
         nerr++;
         $display("FAIL pause_counts: load=%0d en=%0d done=%0d busy=%0d, required 1 4 1 8",
                  n_load, n_en, n_done, n_busy);
      end
      for (int i = 0; i < 5; i++) begin
         nchk++;
         if (q_log[i] !== exp_q[i]) begin
            nerr++;
            $display("FAIL pause_q%0d: q=%0d, required %0d", i, q_log[i], exp_q[i]);
         end
      end
      // pause asserted from the LOAD cycle onward must not block the load
      do_seq(4'd2, 4'd1, 0, 1, 99);
      nchk++;
      if (n_load !== 1 || n_en !== 1 || n_busy !== 3 || q !== 4'd3) begin
         nerr++;
         $display("FAIL pause_in_load: load=%0d en=%0d busy=%0d q=%0d, required 1 1 3 3",
                  n_load, n_en, n_busy, q);
      end
   endtask

   task automatic test_wrap;
      logic [3:0] exp_q [0:3];
      exp_q[0] = 4'd14; exp_q[1] = 4'd15; exp_q[2] = 4'd0; exp_q[3] = 4'd1;
      do_seq(4'd14, 4'd3, 99, 0, 99);
      for (int i = 0; i < 4; i++) begin
         nchk++;
         if (q_log[i] !== exp_q[i]) begin
            nerr++;
            $display("FAIL wrap_q%0d: q=%0d, required %0d", i, q_log[i], exp_q[i]);
         end
      end
      nchk++;
      if (wrap !== 1'b1) begin
         nerr++;
         $display("FAIL wrap_set: wrap=%b, required 1", wrap);
      end
      repeat (2) @(posedge clk);
      #1;
      nchk++;
      if (wrap !== 1'b1) begin
         nerr++;
         $display("FAIL wrap_hold: wrap=%b in idle, required 1", wrap);
      end
   endtask

   task automatic test_start_in_run;
      logic [3:0] exp_q [0:3];
      exp_q[0] = 4'd2; exp_q[1] = 4'd3; exp_q[2] = 4'd4; exp_q[3] = 4'd5;
      do_seq(4'd2, 4'd3, 99, 0, 2);
      nchk++;
      if (wrap_load !== 1'b0) begin
         nerr++;
         $display("FAIL wrap_clear: wrap=%b in LOAD after new start, required 0", wrap_load);
      end
      nchk++;
      if (n_en !== 3 || n_busy !== 5 || n_done !== 1) begin
         nerr++;
         $display("FAIL stray_counts: en=%0d busy=%0d done=%0d, required 3 5 1",
                  n_en, n_busy, n_done);
      end
      for (int i = 0; i < 4; i++) begin
         nchk++;
         if (q_log[i] !== exp_q[i]) begin
            nerr++;
            $display("FAIL stray_q%0d: q=%0d, required %0d", i, q_log[i], exp_q[i]);
         end
      end
      nchk++;
      if (d !== 4'd2) begin
         nerr++;
         $display("FAIL stray_d: d=%0d, required 2", d);
      end
   endtask

   task automatic test_back_to_back;
      preset = 4'd3; run_len = 4'd1; start = 1'b1;
      @(posedge clk); #1;
      nchk++;
      if (load !== 1'b1) begin
         nerr++;
         $display("FAIL b2b_load1: load=%b, required 1", load);
      end
      @(posedge clk); #1;
      nchk++;
      if (en !== 1'b1) begin
         nerr++;
         $display("FAIL b2b_run: en=%b, required 1", en);
      end
      @(posedge clk); #1;
      nchk++;
      if (done !== 1'b1) begin
         nerr++;
         $display("FAIL b2b_done: done=%b, required 1", done);
      end
      @(posedge clk); #1;
      nchk++;
      if (busy !== 1'b0) begin
         nerr++;
         $display("FAIL b2b_idle: busy=%b, required 0", busy);
      end
      preset = 4'd7;
      @(posedge clk); #1;
      start = 1'b0;
      nchk++;
      if (load !== 1'b1 || d !== 4'd7) begin
         nerr++;
         $display("FAIL b2b_restart: load=%b d=%0d, required load=1 d=7", load, d);
      end
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic test_reset_mid_run;
      int saw_done;
      saw_done = 0;
      preset = 4'd1; run_len = 4'd4; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      // RUN with remaining=2
      nchk++;
      if (en !== 1'b1 || busy !== 1'b1 || q !== 4'd3) begin
         nerr++;
         $display("FAIL rst_pre: en=%b busy=%b q=%0d, required 1 1 3", en, busy, q);
      end
      #2;
      rst = 1'b0;
      #1;
      nchk++;
      if ({load, en, busy, done, wrap, d} !== 9'd0) begin
         nerr++;
         $display("FAIL rst_async: load/en/busy/done/wrap/d=%b, required all 0",
                  {load, en, busy, done, wrap, d});
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (done) saw_done++;
      end
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #4;
         if (done) saw_done++;
      end
      nchk++;
      if (saw_done !== 0) begin
         nerr++;
         $display("FAIL rst_no_done: done seen %0d times, required 0", saw_done);
      end
      do_seq(4'd6, 4'd2, 99, 0, 99);
      nchk++;
      if (n_load !== 1 || n_en !== 2 || n_done !== 1 || n_busy !== 4 || q !== 4'd8) begin
         nerr++;
         $display("FAIL rst_rerun: load=%0d en=%0d done=%0d busy=%0d q=%0d, required 1 2 1 4 8",
                  n_load, n_en, n_done, n_busy, q);
      end
   endtask

   initial begin
      nchk = 0;
      nerr = 0;
      test_reset();
      test_basic();
      test_zero_len();
      test_pause();
      test_wrap();
      test_start_in_run();
      test_back_to_back();
      test_reset_mid_run();
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
